// File: rtl/control_unit_pipe_pkg.sv
// Shared definitions for the decode-stage control unit.
//   - opcode encodings (low three bits; any higher opcode bit makes it illegal)
//   - bit positions inside the 9-bit control bundle
//       {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}
//   - NOP bundle constant, FSM state type, opcode legality helper
package control_unit_pipe_pkg;

    localparam int CTRL_W = 9;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_IMMB  = 3'b001;
    localparam logic [2:0] OP_ILL2  = 3'b010;
    localparam logic [2:0] OP_ILL3  = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_IMM   = 3'b111;

    localparam int IDX_REGDST   = 8;
    localparam int IDX_ALUSRC   = 7;
    localparam int IDX_MEMTOREG = 6;
    localparam int IDX_REGWRITE = 5;
    localparam int IDX_MEMREAD  = 4;
    localparam int IDX_MEMWRITE = 3;
    localparam int IDX_BRANCH   = 2;
    localparam int IDX_ALUOP_HI = 1;
    localparam int IDX_ALUOP_LO = 0;

    localparam ctrl_t CTRL_NOP = 9'b0_0_0_0_0_0_0_00;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // An opcode is legal when no bit above [2] is set and it is not 010/011.
    function automatic logic op_is_legal(input logic [2:0] op_low, input logic op_upper);
        return (!op_upper) && (op_low != OP_ILL2) && (op_low != OP_ILL3);
    endfunction

endpackage

// File: rtl/control_unit_pipe_decode.sv
// control_decode_rom: combinational opcode-to-control-bundle table.
// Ports:
//   op_low    in  3  low three opcode bits
//   op_upper  in  1  any opcode bit above [2] is set (forces NOP)
//   ctrl      out 9  {regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop[1:0]}
module control_decode_rom
    import control_unit_pipe_pkg::*;
(
    input  logic [2:0] op_low,
    input  logic       op_upper,
    output ctrl_t      ctrl
);

    // Opcode table; unknown or out-of-range opcodes decode to the NOP bundle.
    always_comb begin
        ctrl = CTRL_NOP;
        if (op_upper) begin
            ctrl = CTRL_NOP;
        end else begin
            case (op_low)
                OP_RTYPE: ctrl = 9'b1_0_0_1_0_0_0_00;
                OP_LW:    ctrl = 9'b0_1_1_1_1_0_0_11;
                OP_SW:    ctrl = 9'b0_1_0_0_0_1_0_11;
                OP_IMM:   ctrl = 9'b0_1_0_1_0_0_0_11;
                OP_BEQ:   ctrl = 9'b0_0_0_0_0_0_1_01;
                OP_IMMB:  ctrl = 9'b0_1_0_1_0_0_0_10;
                default:  ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: decode-stage control unit with the ID/EX control register.
// Decodes the ID opcode, registers the control bundle into EX, inserts a
// one-cycle load-use bubble (with stall to PC and IF/ID) and BR_FLUSH_CYC
// bubbles after every taken branch. Counts inserted bubbles (saturating).
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcodes are bubbled,
// counted and set the sticky illegal_op output).
// Ports:
//   clk, rst (async, active-high)
//   id_valid, id_opcode[OPW], id_rs[REGW], id_rt[REGW], ex_branch_taken  (inputs)
//   stall (combinational), ex_valid, ex_regdst, ex_alusrc, ex_memtoreg,
//   ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop[2],
//   ex_rt[REGW], bubble_cnt[CNTW], illegal_op (trap build only)
module control_unit_pipe
    import control_unit_pipe_pkg::*;
#(
    parameter int OPW          = 3,
    parameter int REGW         = 3,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNTW         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            ex_branch_taken,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic [1:0]      ex_aluop,
    output logic [REGW-1:0] ex_rt,
    output logic [CNTW-1:0] bubble_cnt
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    // Flush counter only needs to hold BR_FLUSH_CYC-1 (at most 2).
    localparam int              FCW        = 2;
    localparam logic [FCW-1:0]  FLUSH_LOAD = FCW'(BR_FLUSH_CYC - 1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [FCW-1:0]  flush_cnt_r;
    logic [FCW-1:0]  flush_cnt_nx_s;
    ctrl_t           ex_ctrl_r;
    ctrl_t           dec_ctrl_s;
    logic [2:0]      op_low_s;
    logic            op_upper_s;
    logic            rt_used_s;
    logic            haz_s;
    logic            illegal_s;
    logic            bubble_s;
    logic            trap_s;

    assign op_low_s   = id_opcode[2:0];
    assign op_upper_s = |(id_opcode >> 3'd3);

    control_decode_rom u_rom (
        .op_low   (op_low_s),
        .op_upper (op_upper_s),
        .ctrl     (dec_ctrl_s)
    );

    // Only R-type, sw and beq actually read rt, so only they hazard on it.
    assign rt_used_s = (!op_upper_s) &&
                       ((op_low_s == OP_RTYPE) || (op_low_s == OP_SW) || (op_low_s == OP_BEQ));

    assign haz_s = ex_valid && ex_memread && id_valid &&
                   ((id_rs == ex_rt) || ((id_rt == ex_rt) && rt_used_s));

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_s = id_valid && !op_is_legal(op_low_s, op_upper_s);
`else
    assign illegal_s = 1'b0;
`endif

    // Next-state, stall and bubble selection; branch flush has priority over load-use.
    always_comb begin
        state_nx_s     = state_r;
        flush_cnt_nx_s = flush_cnt_r;
        stall          = 1'b0;
        bubble_s       = 1'b0;
        trap_s         = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    bubble_s = 1'b1;
                    if (BR_FLUSH_CYC > 1) begin
                        state_nx_s     = ST_FLUSH;
                        flush_cnt_nx_s = FLUSH_LOAD;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else if (haz_s) begin
                    stall    = 1'b1;
                    bubble_s = 1'b1;
                end else if (illegal_s) begin
                    bubble_s = 1'b1;
                    trap_s   = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                bubble_s = 1'b1;
                if (ex_branch_taken) begin
                    flush_cnt_nx_s = FLUSH_LOAD;
                end else if (flush_cnt_r == 2'd1) begin
                    state_nx_s = ST_RUN;
                end else begin
                    flush_cnt_nx_s = flush_cnt_r - 2'd1;
                end
            end
            default: begin
                state_nx_s     = ST_RUN;
                flush_cnt_nx_s = 2'd0;
            end
        endcase
    end

    // FSM state and flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
        end
    end

    // ID/EX control register; ex_rt always follows id_rt, even for bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_ctrl_r <= CTRL_NOP;
            ex_rt     <= '0;
        end else begin
            ex_rt <= id_rt;
            if (bubble_s || !id_valid) begin
                ex_valid  <= 1'b0;
                ex_ctrl_r <= CTRL_NOP;
            end else begin
                ex_valid  <= 1'b1;
                ex_ctrl_r <= dec_ctrl_s;
            end
        end
    end

    // Saturating count of inserted bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_s && (bubble_cnt != {CNTW{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (trap_s) begin
            illegal_op <= 1'b1;
        end else begin
            illegal_op <= illegal_op;
        end
    end
`else
    logic unused_trap_s;
    assign unused_trap_s = trap_s;
`endif

    assign ex_regdst   = ex_ctrl_r[IDX_REGDST];
    assign ex_alusrc   = ex_ctrl_r[IDX_ALUSRC];
    assign ex_memtoreg = ex_ctrl_r[IDX_MEMTOREG];
    assign ex_regwrite = ex_ctrl_r[IDX_REGWRITE];
    assign ex_memread  = ex_ctrl_r[IDX_MEMREAD];
    assign ex_memwrite = ex_ctrl_r[IDX_MEMWRITE];
    assign ex_branch   = ex_ctrl_r[IDX_BRANCH];
    assign ex_aluop    = ex_ctrl_r[IDX_ALUOP_HI:IDX_ALUOP_LO];

endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model that
// tracks "bubbles still owed" rather than an FSM.
module tb_control_unit_pipe;

    localparam int OPW  = 4;
    localparam int REGW = 3;
    localparam int BR   = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [OPW-1:0]  id_opcode = '0;
    logic [REGW-1:0] id_rs = '0;
    logic [REGW-1:0] id_rt = '0;
    logic            ex_branch_taken = 1'b0;
    logic            stall, ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic            ex_memread, ex_memwrite, ex_branch;
    logic [1:0]      ex_aluop;
    logic [REGW-1:0] ex_rt;
    logic [CNTW-1:0] bubble_cnt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic            illegal_op;
`endif

    always #5 clk = ~clk;

    control_unit_pipe #(.OPW(OPW), .REGW(REGW), .BR_FLUSH_CYC(BR), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
        .ex_rt(ex_rt), .bubble_cnt(bubble_cnt)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_valid;
    bit [8:0]      m_ctrl;
    bit [REGW-1:0] m_rt;
    int            m_bub;
    int            m_left;   // flush bubbles still owed after the current one
    bit            m_ill;

    // Bundle straight from the decode table, {regdst..aluop}.
    function automatic bit [8:0] spec_bundle(input int op);
        case (op)
            0:       return 9'b100100000;
            4:       return 9'b011110011;
            5:       return 9'b010001011;
            7:       return 9'b010100011;
            6:       return 9'b000000101;
            1:       return 9'b010100010;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic bit op_legal(input int op);
        return (op < 8) && (op != 2) && (op != 3);
    endfunction

    function automatic bit model_haz();
        int op;
        op = int'(id_opcode);
        return m_valid && m_ctrl[4] && id_valid &&
               ((id_rs == m_rt) || ((id_rt == m_rt) && (op == 0 || op == 5 || op == 6)));
    endfunction

    function automatic bit model_stall();
        return model_haz() && !ex_branch_taken && (m_left == 0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_rt = '0; m_bub = 0; m_left = 0; m_ill = 0;
    endtask

    task automatic model_edge();
        bit bub;
        bub = 0;
        if (m_left > 0 || ex_branch_taken) begin
            bub = 1;
            m_left = ex_branch_taken ? BR - 1 : m_left - 1;
        end else if (model_haz()) begin
            bub = 1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        else if (id_valid && !op_legal(int'(id_opcode))) begin
            bub = 1;
            m_ill = 1;
        end
`endif
        if (bub) begin
            m_valid = 0;
            m_ctrl  = '0;
            if (m_bub < CMAX) m_bub++;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? spec_bundle(int'(id_opcode)) : 9'd0;
        end
        m_rt = id_rt;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input int op, input int rs, input int rt, input bit br);
        id_valid        = v;
        id_opcode       = OPW'(op);
        id_rs           = REGW'(rs);
        id_rt           = REGW'(rt);
        ex_branch_taken = br;
    endtask

    // One clock: stall checked mid-cycle, registered outputs just after the edge.
    task automatic tick();
        @(negedge clk);
        check_eq("stall", {31'd0, stall}, {31'd0, model_stall()});
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        check_eq("ex_ctrl", {23'd0, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                             ex_memread, ex_memwrite, ex_branch, ex_aluop}, {23'd0, m_ctrl});
        check_eq("ex_rt", 32'(ex_rt), 32'(m_rt));
        check_eq("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
`endif
    endtask

    // Asynchronous reset pulse between clock edges, outputs checked before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("rst_ex_ctrl", {23'd0, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                                 ex_memread, ex_memwrite, ex_branch, ex_aluop}, 32'd0);
        check_eq("rst_ex_rt", 32'(ex_rt), 32'd0);
        check_eq("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
`endif
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // load-use: lw rt=3 then add rs=3 -> one stall, add follows one cycle later
        drive(1, 4, 0, 3, 0); tick();
        drive(1, 0, 3, 1, 0); tick();
        check_eq("lu_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        check_eq("lu_add_in_ex", {31'd0, ex_regdst & ex_regwrite & ex_valid}, 32'd1);
        check_eq("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // lw then sw rs=1 rt=3 -> stall; lw then lw rt=3 -> no stall
        drive(1, 4, 0, 3, 0); tick();
        drive(1, 5, 1, 3, 0); tick(); tick();
        drive(1, 4, 0, 3, 0); tick();
        drive(1, 4, 0, 3, 0); tick();
        check_eq("lw_lw_no_bubble", 32'(bubble_cnt), 32'd2);

        // taken branch pulse -> BR bubbles, stall low throughout
        drive(1, 7, 1, 2, 1); tick();
        drive(1, 7, 1, 2, 0); tick(); tick();
        check_eq("br_bubbles", 32'(bubble_cnt), 32'd4);

        // branch together with load-use hazard -> flush wins, no stall
        drive(1, 4, 0, 5, 0); tick();
        drive(1, 0, 5, 5, 1); tick();
        drive(1, 0, 5, 5, 0); tick(); tick();

        // every legal opcode through the table
        for (int i = 0; i < 8; i++) begin
            if (op_legal(i)) begin
                drive(1, i, 6, 7, 0);
                tick();
            end
        end
        // illegal opcodes: 010 and one with an upper bit set
        drive(1, 2, 6, 7, 0); tick();
        drive(1, 12, 6, 7, 0); tick();
        drive(1, 7, 6, 7, 0); tick();

        // reset in the middle of a flush, then normal decode
        drive(1, 7, 1, 2, 1); tick();
        do_reset();
        drive(1, 7, 1, 2, 0); tick();
        check_eq("post_rst_imm", {23'd0, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                                  ex_memread, ex_memwrite, ex_branch, ex_aluop}, 32'h0A3);

        // randomized traffic; a stalled instruction is held in ID
        for (int n = 0; n < 400; n++) begin
            if (!model_stall()) begin
                drive($urandom_range(0, 9) != 0,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $urandom_range(0, 9) == 0);
            end else begin
                ex_branch_taken = ($urandom_range(0, 4) == 0);
            end
            tick();
        end

        // saturation of the bubble counter
        drive(1, 0, 0, 0, 1);
        for (int n = 0; n < 20; n++) tick();
        check_eq("bubble_sat", 32'(bubble_cnt), 32'(CMAX));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
